// File: rtl/l1_icache_fill_ctrl_if.sv
// Bundle of fetch-miss, L2 line-read and L1 fill signals for the I$ fill controller.
// master = fill controller, slave = fetch/L2/array environment.
interface l1_icache_fill_ctrl_if #(
  parameter int PC_W          = 32,
  parameter int INST_W        = 32,
  parameter int INSTS_IN_LINE = 8,
  parameter int INDEX_BITS    = 5,
  parameter int TAG_BITS      = 22
);
  localparam int LINE_W = INSTS_IN_LINE * INST_W;

  logic                  miss_valid_i;
  logic [PC_W-1:0]       miss_addr_i;
  logic                  miss_ready_o;
  logic                  flush_i;
  logic [PC_W-1:0]       mem_addr0_o;
  logic                  mem_re0_o;
  logic [LINE_W-1:0]     mem_data0_i;
  logic                  mem_data_ready0_i;
  logic [TAG_BITS-1:0]   mem_tag0_i;
  logic [INDEX_BITS-1:0] mem_index0_i;
  logic                  fill_valid_o;
  logic [TAG_BITS-1:0]   fill_tag_o;
  logic [INDEX_BITS-1:0] fill_index_o;
  logic [LINE_W-1:0]     fill_data_o;
  logic                  fill_error_o;
  logic                  busy_o;

  modport master (
    input  miss_valid_i, miss_addr_i, flush_i,
    input  mem_data0_i, mem_data_ready0_i, mem_tag0_i, mem_index0_i,
    output miss_ready_o, mem_addr0_o, mem_re0_o,
    output fill_valid_o, fill_tag_o, fill_index_o, fill_data_o, fill_error_o, busy_o
  );

  modport slave (
    output miss_valid_i, miss_addr_i, flush_i,
    output mem_data0_i, mem_data_ready0_i, mem_tag0_i, mem_index0_i,
    input  miss_ready_o, mem_addr0_o, mem_re0_o,
    input  fill_valid_o, fill_tag_o, fill_index_o, fill_data_o, fill_error_o, busy_o
  );
endinterface

// File: rtl/l1_icache_fill_ctrl.sv
// L1-I$ line-fill requester: one outstanding miss, single-cycle read strobe, tag/index-checked
// one-cycle fill, with flush cancellation (DRAIN) and a response timeout.
module l1_icache_fill_ctrl #(
  parameter int PC_W          = 32,
  parameter int INST_W        = 32,
  parameter int INSTS_IN_LINE = 8,
  parameter int INDEX_BITS    = 5,
  parameter int TAG_BITS      = 22,
  parameter int TIMEOUT       = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  l1_icache_fill_ctrl_if.master bus
);
  localparam int OFF_BITS = $clog2(INSTS_IN_LINE);
  localparam int LO_BITS  = OFF_BITS + 2;
  localparam int LINE_W   = INSTS_IN_LINE * INST_W;
  localparam int TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [PC_W-1:0]       addr_q, addr_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;
  logic [INDEX_BITS-1:0] fill_index_q, fill_index_d;
  logic [LINE_W-1:0]     fill_data_q, fill_data_d;
  logic                  fill_error_q, fill_error_d;
  logic                  resp_match;

  assign resp_match = (bus.mem_tag0_i == addr_q[PC_W-1 -: TAG_BITS]) &&
                      (bus.mem_index0_i == addr_q[LO_BITS +: INDEX_BITS]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      timer_q      <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      fill_data_q  <= '0;
      fill_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      fill_tag_q   <= fill_tag_d;
      fill_index_q <= fill_index_d;
      fill_data_q  <= fill_data_d;
      fill_error_q <= fill_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    timer_d      = timer_q;
    fill_tag_d   = fill_tag_q;
    fill_index_d = fill_index_q;
    fill_data_d  = fill_data_q;
    fill_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.miss_valid_i && !bus.flush_i) begin
          addr_d  = {bus.miss_addr_i[PC_W-1:LO_BITS], {LO_BITS{1'b0}}};
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // The strobe is already on the bus, so a flush here still has to drain the response.
        timer_d = '0;
        state_d = bus.flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.mem_data_ready0_i) begin
          fill_tag_d   = bus.mem_tag0_i;
          fill_index_d = bus.mem_index0_i;
          fill_data_d  = bus.mem_data0_i;
          if (resp_match) begin
            state_d = S_FILL;
          end else begin
            fill_error_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else if (timer_q == TMR_LAST) begin
          // Timeout beats a same-cycle flush so the total wait never exceeds TIMEOUT cycles.
          fill_error_d = 1'b1;
          state_d      = S_IDLE;
        end else if (bus.flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.mem_data_ready0_i) begin
          state_d = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          fill_error_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.miss_ready_o = (state_q == S_IDLE) && !reset;
    bus.mem_re0_o    = (state_q == S_REQ);
    bus.mem_addr0_o  = addr_q;
    bus.fill_valid_o = (state_q == S_FILL);
    bus.fill_tag_o   = fill_tag_q;
    bus.fill_index_o = fill_index_q;
    bus.fill_data_o  = fill_data_q;
    bus.fill_error_o = fill_error_q;
    bus.busy_o       = (state_q != S_IDLE);
  end
endmodule

// File: tb/tb_l1_icache_fill_ctrl.sv
// Directed bench for l1_icache_fill_ctrl: request-lifetime model checked every cycle plus
// literal expectations for the fill, flush, mismatch, timeout, flush-vs-miss and reset cases.
module tb_l1_icache_fill_ctrl;
  localparam int PC_W = 32, INST_W = 32, INSTS_IN_LINE = 8, INDEX_BITS = 5, TAG_BITS = 22;
  localparam int TIMEOUT = 64;
  localparam int LINE_W = INSTS_IN_LINE * INST_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_icache_fill_ctrl_if #(.PC_W(PC_W), .INST_W(INST_W), .INSTS_IN_LINE(INSTS_IN_LINE),
                           .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) bus_if ();

  l1_icache_fill_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .INSTS_IN_LINE(INSTS_IN_LINE),
                        .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .reset(reset), .bus(bus_if.master));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, got, exp);
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < INSTS_IN_LINE; i++) l[i*INST_W +: INST_W] = seed + i * 32'h0101_0101;
    return l;
  endfunction

  // Model of one request's lifetime, indexed by cycle numbers rather than controller states.
  bit                    chk_en = 1'b0;
  int                    cyc = 0;
  bit                    m_busy = 1'b0;
  bit                    m_cancel = 1'b0;
  int                    m_acc = -10;
  int                    m_fill_cyc = -1;
  int                    m_err_cyc = -1;
  int                    k;
  bit                    e_re;
  logic [PC_W-1:0]       m_line = '0;
  logic [TAG_BITS-1:0]   m_ftag = '0;
  logic [INDEX_BITS-1:0] m_fidx = '0;
  logic [LINE_W-1:0]     m_fdata = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      e_re = m_busy && (cyc == m_acc + 1);
      chk("busy", bus_if.busy_o, m_busy);
      chk("miss_ready", bus_if.miss_ready_o, !m_busy && !reset);
      chk("mem_re", bus_if.mem_re0_o, e_re);
      if (e_re) chk("mem_addr", bus_if.mem_addr0_o, m_line);
      chk("fill_valid", bus_if.fill_valid_o, cyc == m_fill_cyc);
      chk("fill_error", bus_if.fill_error_o, cyc == m_err_cyc);
      chk("fill_tag", bus_if.fill_tag_o, m_ftag);
      chk("fill_index", bus_if.fill_index_o, m_fidx);
      chk("fill_data", bus_if.fill_data_o, m_fdata);

      if (reset) begin
        m_busy = 0; m_cancel = 0; m_fill_cyc = -1; m_err_cyc = -1;
        m_line = '0; m_ftag = '0; m_fidx = '0; m_fdata = '0;
      end else if (!m_busy) begin
        if (bus_if.miss_valid_i && !bus_if.flush_i) begin
          m_busy = 1; m_cancel = 0; m_acc = cyc;
          m_line = bus_if.miss_addr_i & ~32'h1F;
        end
      end else if (cyc == m_fill_cyc) begin
        m_busy = 0;
      end else begin
        k = cyc - m_acc - 1;  // 0 = strobe cycle, k >= 1 = k-th wait cycle
        if (k == 0) begin
          if (bus_if.flush_i) m_cancel = 1;
        end else if (bus_if.mem_data_ready0_i) begin
          if (m_cancel) begin
            m_busy = 0;
          end else begin
            m_ftag = bus_if.mem_tag0_i; m_fidx = bus_if.mem_index0_i; m_fdata = bus_if.mem_data0_i;
            if (bus_if.mem_tag0_i == m_line[31:10] && bus_if.mem_index0_i == m_line[9:5])
              m_fill_cyc = cyc + 1;
            else begin
              m_err_cyc = cyc + 1; m_busy = 0;
            end
          end
        end else if (k == TIMEOUT) begin
          m_err_cyc = cyc + 1; m_busy = 0;
        end else if (bus_if.flush_i) begin
          m_cancel = 1;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a miss in an IDLE cycle; returns in the strobe cycle.
  task automatic issue(input logic [PC_W-1:0] a);
    bus_if.miss_valid_i = 1'b1;
    bus_if.miss_addr_i  = a;
    tick();
    bus_if.miss_valid_i = 1'b0;
  endtask

  task automatic drive_resp(input logic [TAG_BITS-1:0] t, input logic [INDEX_BITS-1:0] ix,
                            input logic [LINE_W-1:0] d);
    bus_if.mem_data_ready0_i = 1'b1;
    bus_if.mem_tag0_i        = t;
    bus_if.mem_index0_i      = ix;
    bus_if.mem_data0_i       = d;
  endtask

  initial begin
    reset = 1'b1;
    bus_if.miss_valid_i = 0; bus_if.miss_addr_i = '0; bus_if.flush_i = 0;
    bus_if.mem_data0_i = '0; bus_if.mem_data_ready0_i = 0;
    bus_if.mem_tag0_i = '0; bus_if.mem_index0_i = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    tick();
    chk("rst_busy", bus_if.busy_o, 1'b0);
    chk("rst_miss_ready", bus_if.miss_ready_o, 1'b0);
    chk("rst_fill_tag", bus_if.fill_tag_o, '0);
    reset = 1'b0;
    tick();

    // 1: basic fill, penalty 2
    issue(32'h0000_1234);
    chk("t1_re", bus_if.mem_re0_o, 1'b1);
    chk("t1_addr", bus_if.mem_addr0_o, 32'h0000_1220);
    tick();
    tick();
    drive_resp(22'h4, 5'h11, mk_line(32'h100));
    tick();
    bus_if.mem_data_ready0_i = 1'b0;
    chk("t1_fill_valid", bus_if.fill_valid_o, 1'b1);
    chk("t1_fill_index", bus_if.fill_index_o, 5'h11);
    chk("t1_fill_tag", bus_if.fill_tag_o, 22'h4);
    chk("t1_fill_data", bus_if.fill_data_o, mk_line(32'h100));
    tick();
    chk("t1_ready_again", bus_if.miss_ready_o, 1'b1);
    tick();

    // 2: flush in first wait cycle, late response discarded
    issue(32'h0000_3300);
    tick();
    bus_if.flush_i = 1'b1;
    tick();
    bus_if.flush_i = 1'b0;
    chk("t2_busy_drain", bus_if.busy_o, 1'b1);
    tick();
    drive_resp(22'hC, 5'h18, mk_line(32'h200));
    tick();
    bus_if.mem_data_ready0_i = 1'b0;
    chk("t2_miss_ready", bus_if.miss_ready_o, 1'b1);
    chk("t2_no_fill", bus_if.fill_valid_o, 1'b0);
    chk("t2_no_error", bus_if.fill_error_o, 1'b0);
    chk("t2_tag_kept", bus_if.fill_tag_o, 22'h4);
    tick();

    // 3: tag mismatch
    issue(32'h0000_1234);
    tick();
    tick();
    drive_resp(22'h5, 5'h11, mk_line(32'h300));
    tick();
    bus_if.mem_data_ready0_i = 1'b0;
    chk("t3_error", bus_if.fill_error_o, 1'b1);
    chk("t3_no_fill", bus_if.fill_valid_o, 1'b0);
    chk("t3_idle", bus_if.busy_o, 1'b0);
    chk("t3_tag", bus_if.fill_tag_o, 22'h5);
    tick();
    chk("t3_error_pulse", bus_if.fill_error_o, 1'b0);

    // 4: timeout, then a stale response
    issue(32'h8000_0040);
    repeat (TIMEOUT) tick();
    chk("t4_busy_w64", bus_if.busy_o, 1'b1);
    chk("t4_no_err_w64", bus_if.fill_error_o, 1'b0);
    tick();
    chk("t4_error", bus_if.fill_error_o, 1'b1);
    chk("t4_idle", bus_if.busy_o, 1'b0);
    repeat (10) tick();
    drive_resp(22'h20_0000, 5'h02, mk_line(32'h400));
    tick();
    bus_if.mem_data_ready0_i = 1'b0;
    chk("t4_stale_idle", bus_if.busy_o, 1'b0);
    chk("t4_stale_nofill", bus_if.fill_valid_o, 1'b0);
    tick();

    // 5: flush beats miss in IDLE
    bus_if.miss_valid_i = 1'b1; bus_if.miss_addr_i = 32'h0000_2000; bus_if.flush_i = 1'b1;
    tick();
    chk("t5_no_accept", bus_if.busy_o, 1'b0);
    chk("t5_no_re", bus_if.mem_re0_o, 1'b0);
    bus_if.flush_i = 1'b0;
    tick();
    bus_if.miss_valid_i = 1'b0;
    chk("t5_re", bus_if.mem_re0_o, 1'b1);
    chk("t5_addr", bus_if.mem_addr0_o, 32'h0000_2000);
    tick();
    drive_resp(22'h8, 5'h00, mk_line(32'h500));
    tick();
    bus_if.mem_data_ready0_i = 1'b0;
    chk("t5_fill", bus_if.fill_valid_o, 1'b1);
    chk("t5_tag", bus_if.fill_tag_o, 22'h8);
    tick();

    // 6: reset during wait with a response in the same cycle
    issue(32'h0000_1234);
    tick();
    reset = 1'b1;
    drive_resp(22'h4, 5'h11, mk_line(32'h600));
    tick();
    chk("t6_busy", bus_if.busy_o, 1'b0);
    chk("t6_fill", bus_if.fill_valid_o, 1'b0);
    chk("t6_err", bus_if.fill_error_o, 1'b0);
    chk("t6_tag", bus_if.fill_tag_o, '0);
    chk("t6_data", bus_if.fill_data_o, '0);
    reset = 1'b0;
    tick();
    bus_if.mem_data_ready0_i = 1'b0;
    chk("t6_stale_idle", bus_if.busy_o, 1'b0);
    issue(32'h0000_1234);
    chk("t6_re", bus_if.mem_re0_o, 1'b1);
    tick();
    tick();
    drive_resp(22'h4, 5'h11, mk_line(32'h700));
    tick();
    bus_if.mem_data_ready0_i = 1'b0;
    chk("t6_fill_after", bus_if.fill_valid_o, 1'b1);
    chk("t6_data_after", bus_if.fill_data_o, mk_line(32'h700));
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
